// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution for a MIPS32-style EXEC stage: decode, link write, delay-slot tracking, redirect.
// Optional statistics counters are compiled in with `define BRANCH_STATS_EN.
module branch_resolve_unit #(
  parameter int unsigned DELAY_SLOTS = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exec,
  input  logic              stall,
  input  logic [31:0]       instruction_word,
  input  logic [31:0]       pc,
  input  logic [31:0]       rs_data,
  input  logic [31:0]       rt_data,
  output logic              link_we,
  output logic [4:0]        link_addr,
  output logic [31:0]       link_data,
  output logic              redirect_valid,
  output logic [31:0]       redirect_target,
  output logic              pending,
  output logic              slot_err
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  taken_count
`endif
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;
  localparam logic [1:0] SLOTS      = 2'(DELAY_SLOTS);

  typedef enum logic [1:0] {IDLE, PENDING, REDIRECT} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] target_q, target_d;
  logic        slot_err_q, slot_err_d;

  logic        accept;
  logic        is_cf, taken, link;
  logic [4:0]  link_rd;
  logic [31:0] tgt;
  logic [31:0] pc_plus4, br_tgt, jmp_tgt;
  logic        rs_neg, rs_zero;
  logic [5:0]  op, funct;
  logic [4:0]  rt_f, rd_f;

  assign accept   = exec & ~stall;
  assign op       = instruction_word[31:26];
  assign rt_f     = instruction_word[20:16];
  assign rd_f     = instruction_word[15:11];
  assign funct    = instruction_word[5:0];
  assign pc_plus4 = pc + 32'd4;
  assign br_tgt   = pc_plus4 + {{14{instruction_word[15]}}, instruction_word[15:0], 2'b00};
  assign jmp_tgt  = {pc_plus4[31:28], instruction_word[25:0], 2'b00};
  assign rs_neg   = rs_data[31];
  assign rs_zero  = (rs_data == '0);

  always_comb begin
    is_cf   = 1'b0;
    taken   = 1'b0;
    link    = 1'b0;
    link_rd = 5'd31;
    tgt     = br_tgt;
    unique case (op)
      OP_SPECIAL: begin
        if (funct == FN_JR || funct == FN_JALR) begin
          is_cf = 1'b1;
          taken = 1'b1;
          tgt   = rs_data;
          if (funct == FN_JALR) begin
            link    = 1'b1;
            link_rd = rd_f;
          end
        end
      end
      OP_REGIMM: begin
        unique case (rt_f)
          RT_BLTZ:   begin is_cf = 1'b1; taken = rs_neg;  end
          RT_BGEZ:   begin is_cf = 1'b1; taken = ~rs_neg; end
          RT_BLTZAL: begin is_cf = 1'b1; taken = rs_neg;  link = 1'b1; end
          RT_BGEZAL: begin is_cf = 1'b1; taken = ~rs_neg; link = 1'b1; end
          default: ;
        endcase
      end
      OP_J:    begin is_cf = 1'b1; taken = 1'b1; tgt = jmp_tgt; end
      OP_JAL:  begin is_cf = 1'b1; taken = 1'b1; tgt = jmp_tgt; link = 1'b1; end
      OP_BEQ:  begin is_cf = 1'b1; taken = (rs_data == rt_data); end
      OP_BNE:  begin is_cf = 1'b1; taken = (rs_data != rt_data); end
      OP_BLEZ: begin is_cf = 1'b1; taken = rs_neg | rs_zero; end
      OP_BGTZ: begin is_cf = 1'b1; taken = ~rs_neg & ~rs_zero; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      target_q   <= '0;
      slot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      slot_err_q <= slot_err_d;
    end
  end

  // REDIRECT behaves as IDLE for a newly accepted taken branch, so the pulse can chain.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    slot_err_d = slot_err_q;
    unique case (state_q)
      IDLE, REDIRECT: begin
        state_d = IDLE;
        if (accept && is_cf && taken) begin
          target_d = tgt;
          if (DELAY_SLOTS == 0) begin
            state_d = REDIRECT;
          end else begin
            state_d = PENDING;
            cnt_d   = SLOTS;
          end
        end
      end
      PENDING: begin
        if (accept) begin
          if (is_cf) slot_err_d = 1'b1;
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = REDIRECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    link_we         = accept & link;
    link_addr       = link_rd;
    link_data       = pc + 32'd8;
    redirect_valid  = (state_q == REDIRECT);
    pending         = (state_q == PENDING);
    redirect_target = target_q;
    slot_err        = slot_err_q;
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] br_cnt_q, tk_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else if (accept && is_cf) begin
      if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + 1'b1;
      if (taken && tk_cnt_q != '1) tk_cnt_q <= tk_cnt_q + 1'b1;
    end
  end

  assign branch_count = br_cnt_q;
  assign taken_count  = tk_cnt_q;
`endif

endmodule
